pe_stream_feeder: RTL and testbench
===================================

PE_STREAM_FEEDER -- requirements
Module: pe_stream_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of filter and ifmap words.
REQ-002 SHALL have parameter CONFIG_BIT, default 5: width of the size configuration inputs.
REQ-003 SHALL have parameter FILTER_DEPTH, default 8: local filter store entries.
REQ-004 SHALL have parameter IFMAP_DEPTH, default 32: local ifmap store entries.
REQ-005 SHALL have parameter GAP_CYCLES, default 2: idle cycles between the filter phase and the ifmap phase.
REQ-006 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_wen  in  1  local store write strobe.
- ld_sel  in  1  store select: 0 = filter, 1 = ifmap.
- ld_addr  in  $clog2(IFMAP_DEPTH)  store write address.
- ld_data  in  DATA_WIDTH  store write data.
- filter_size  in  CONFIG_BIT  number of filter words to send.
- ifmap_count  in  8  number of ifmap words to send.
- go  in  1  start-transfer request.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- filter_wen  out  1  filter word valid.
- filter_din  out  DATA_WIDTH  filter word.
- filter_ready  in  1  PE accepts filter word.
- filter_done  out  1  all filter words sent.
- start  out  1  ifmap phase active.
- ifmap_wen  out  1  ifmap word valid.
- ifmap_din  out  DATA_WIDTH  ifmap word.
- ifmap_ready  in  1  PE accepts ifmap word.

Function
REQ-007 SHALL implement states IDLE, FILTER, GAP, IFMAP, FIN.
REQ-008 SHALL count a transfer on each rising edge where wen and the matching ready are both 1.
REQ-009 SHALL hold wen high and din stable until the transfer completes; wen SHALL NOT drop while ready is 0.
REQ-010 SHALL sustain one word per cycle when ready stays high, with no bubbles.
REQ-011 IDLE: when go=1, SHALL latch filter_size and ifmap_count and enter FILTER, with filter_wen=1 and filter_din=filter store[0] in the next cycle.
- Sizes SHALL be clamped to FILTER_DEPTH and IFMAP_DEPTH respectively.
REQ-012 FILTER: SHALL send filter store[0..filter_size-1] in order; after the last transfer, SHALL set filter_wen=0 and filter_done=1 and enter GAP.
REQ-013 GAP: SHALL stay exactly GAP_CYCLES cycles, then enter IFMAP with start=1, ifmap_wen=1 and ifmap_din=ifmap store[0].
REQ-014 IFMAP: SHALL send ifmap store[0..ifmap_count-1] in order; start SHALL remain 1 through the last transfer cycle and SHALL be 0 in the following cycle, then enter FIN.
REQ-015 FIN: SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-016 filter_done SHALL stay 1 from the end of the filter phase until the next accepted go, which SHALL clear it.
REQ-017 busy SHALL be 1 in FILTER, GAP and IFMAP, and 0 in IDLE and FIN.
REQ-018 A latched filter_size of 0 SHALL skip FILTER: filter_done=1 and the block enters GAP directly.
REQ-019 A latched ifmap_count of 0 SHALL skip IFMAP: start is never raised and the block enters FIN after GAP.
REQ-020 go while busy or in FIN SHALL be ignored.
REQ-021 ld_wen SHALL write the selected store only in IDLE; writes in any other state SHALL be dropped.
- Filter writes with ld_addr >= FILTER_DEPTH SHALL be dropped.
REQ-022 Transfer counters SHALL be $clog2(depth)+1 bits wide and SHALL never wrap within a transfer.
REQ-023 Simultaneous ld_wen and go in IDLE SHALL perform the write and then start.
- The first sent word SHALL reflect that write if it targets address 0 of the filter store.

Reset
REQ-024 On rst=1, the block SHALL go to IDLE immediately, asynchronously.
- busy, done, filter_wen, filter_done, start and ifmap_wen SHALL be 0.
- filter_din, ifmap_din and the counters SHALL be 0.
REQ-025 Store contents SHALL be retained through reset.
REQ-026 Reset mid-transfer SHALL abort the transfer; the next go SHALL restart from word 0.

Verification
REQ-027 Load filter {1,2,3,4}, ifmap 0..23; filter_size=4, ifmap_count=24, ready always 1, go -> 4 consecutive filter words 1,2,3,4; filter_done=1; 2 gap cycles; 24 consecutive ifmap words 0..23 with start=1; done pulse; total 31 cycles from go to done.
REQ-028 filter_ready toggles 1,0,0,1,... -> each filter word held stable while ready=0; no word duplicated or skipped.
REQ-029 filter_size=0, ifmap_count=3 -> filter_done=1 in the cycle after go; filter_wen never 1; 3 ifmap words sent.
REQ-030 rst asserted during ifmap word 10 -> all outputs 0 in the same cycle; the next go resends from filter word 0 with the stored data unchanged.
REQ-031 go pulsed during IFMAP, and ld_wen during FILTER -> no restart, store unchanged, transfer completes normally.
REQ-032 filter_size=31, ifmap_count=200 -> clamped to 8 and 32 words respectively.

Source files
------------

// File: rtl/pe_stream_feeder.sv
// Streams a filter burst, then an ifmap burst, from small local stores into a PE
// using a wen/ready handshake, with a fixed idle gap between the two bursts.
module pe_stream_feeder #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned CONFIG_BIT   = 5,
  parameter int unsigned FILTER_DEPTH = 8,
  parameter int unsigned IFMAP_DEPTH  = 32,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ld_wen,
  input  logic                           ld_sel,
  input  logic [$clog2(IFMAP_DEPTH)-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]          ld_data,
  input  logic [CONFIG_BIT-1:0]          filter_size,
  input  logic [7:0]                     ifmap_count,
  input  logic                           go,
  output logic                           busy,
  output logic                           done,
  output logic                           filter_wen,
  output logic [DATA_WIDTH-1:0]          filter_din,
  input  logic                           filter_ready,
  output logic                           filter_done,
  output logic                           start,
  output logic                           ifmap_wen,
  output logic [DATA_WIDTH-1:0]          ifmap_din,
  input  logic                           ifmap_ready
);

  localparam int unsigned FAW = $clog2(FILTER_DEPTH);
  localparam int unsigned IAW = $clog2(IFMAP_DEPTH);
  localparam int unsigned FCW = FAW + 1;
  localparam int unsigned ICW = IAW + 1;
  localparam int unsigned GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StFilter, StGap, StIfmap, StFin} state_e;

  state_e          state_q, state_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d, fsize_q, fsize_d, fsize_clamp;
  logic [ICW-1:0]  icnt_q, icnt_d, isize_q, isize_d, isize_clamp;
  logic [GCW-1:0]  gcnt_q, gcnt_d;
  logic            fdone_q, fdone_d;

  logic [DATA_WIDTH-1:0] fstore_q [FILTER_DEPTH];
  logic [DATA_WIDTH-1:0] istore_q [IFMAP_DEPTH];

  // Stores have no reset so their contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (ld_wen && (state_q == StIdle)) begin
      if (!ld_sel && (32'(ld_addr) < FILTER_DEPTH)) begin
        fstore_q[ld_addr[FAW-1:0]] <= ld_data;
      end
      if (ld_sel && (32'(ld_addr) < IFMAP_DEPTH)) begin
        istore_q[ld_addr] <= ld_data;
      end
    end
  end

  always_comb begin
    if (32'(filter_size) > FILTER_DEPTH) fsize_clamp = FCW'(FILTER_DEPTH);
    else                                 fsize_clamp = FCW'(filter_size);
    if (32'(ifmap_count) > IFMAP_DEPTH)  isize_clamp = ICW'(IFMAP_DEPTH);
    else                                 isize_clamp = ICW'(ifmap_count);
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    icnt_d  = icnt_q;
    fsize_d = fsize_q;
    isize_d = isize_q;
    gcnt_d  = gcnt_q;
    fdone_d = fdone_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          fsize_d = fsize_clamp;
          isize_d = isize_clamp;
          fcnt_d  = '0;
          icnt_d  = '0;
          gcnt_d  = '0;
          if (fsize_clamp == '0) begin
            fdone_d = 1'b1;
            state_d = StGap;
          end else begin
            fdone_d = 1'b0;
            state_d = StFilter;
          end
        end
      end
      StFilter: begin
        if (filter_ready) begin
          fcnt_d = fcnt_q + FCW'(1);
          if (fcnt_q + FCW'(1) == fsize_q) begin
            fdone_d = 1'b1;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gcnt_q == GCW'(GAP_CYCLES - 1)) begin
          gcnt_d  = '0;
          state_d = (isize_q == '0) ? StFin : StIfmap;
        end else begin
          gcnt_d = gcnt_q + GCW'(1);
        end
      end
      StIfmap: begin
        if (ifmap_ready) begin
          icnt_d = icnt_q + ICW'(1);
          if (icnt_q + ICW'(1) == isize_q) state_d = StFin;
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      fcnt_q  <= '0;
      icnt_q  <= '0;
      fsize_q <= '0;
      isize_q <= '0;
      gcnt_q  <= '0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      icnt_q  <= icnt_d;
      fsize_q <= fsize_d;
      isize_q <= isize_d;
      gcnt_q  <= gcnt_d;
      fdone_q <= fdone_d;
    end
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  assign busy        = (state_q == StFilter) || (state_q == StGap) || (state_q == StIfmap);
  assign done        = (state_q == StFin);
  assign filter_wen  = (state_q == StFilter);
  assign filter_done = fdone_q;
  assign start       = (state_q == StIfmap);
  assign ifmap_wen   = (state_q == StIfmap);
  assign filter_din  = filter_wen ? fstore_q[fcnt_q[FAW-1:0]] : '0;
  assign ifmap_din   = ifmap_wen ? istore_q[icnt_q[IAW-1:0]] : '0;

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Directed bench for pe_stream_feeder: table of transfer configurations plus
// hand-written sequences for stalls, disturbances, reset abort and write-with-go.
module tb_pe_stream_feeder;

  localparam int DW = 16;
  localparam int FD = 8;
  localparam int ID = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_wen, ld_sel;
  logic [4:0]    ld_addr;
  logic [DW-1:0] ld_data;
  logic [4:0]    filter_size;
  logic [7:0]    ifmap_count;
  logic          go;
  logic          busy, done, filter_wen, filter_done, start, ifmap_wen;
  logic [DW-1:0] filter_din, ifmap_din;
  logic          filter_ready, ifmap_ready;

  pe_stream_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .ld_wen       (ld_wen),
    .ld_sel       (ld_sel),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .filter_size  (filter_size),
    .ifmap_count  (ifmap_count),
    .go           (go),
    .busy         (busy),
    .done         (done),
    .filter_wen   (filter_wen),
    .filter_din   (filter_din),
    .filter_ready (filter_ready),
    .filter_done  (filter_done),
    .start        (start),
    .ifmap_wen    (ifmap_wen),
    .ifmap_din    (ifmap_din),
    .ifmap_ready  (ifmap_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fs;
    int ic;
    int mode;     // 0: ready high, 1: stalling readies
    int exp_nf;
    int exp_ni;
    int exp_cyc;  // -1: cycle count not checked
  } vec_t;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] fmem [FD];
  logic [DW-1:0] imem [ID];
  logic [3:0]    rpat = 4'b1001;
  vec_t          vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int any_out();
    return int'(busy | done | filter_wen | filter_done | start | ifmap_wen |
                (|filter_din) | (|ifmap_din));
  endfunction

  task automatic load(input bit sel, input int addr, input logic [DW-1:0] d);
    @(negedge clk);
    ld_wen = 1'b1; ld_sel = sel; ld_addr = 5'(addr); ld_data = d;
    @(negedge clk);
    ld_wen = 1'b0;
    if (!sel && addr < FD) fmem[addr] = d;
    if (sel && addr < ID) imem[addr] = d;
  endtask

  // mode 2 pokes go during IFMAP/FIN and ld_wen during FILTER; both must be ignored.
  task automatic run_xfer(input string tag, input int fs, input int ic, input int mode,
                          input int exp_nf, input int exp_ni, input int exp_cyc,
                          input int abort_at, input bit wr_go, input logic [DW-1:0] wdata);
    int nf, ni, done_k;
    bit fhold, ihold;
    logic [DW-1:0] fprev, iprev;
    @(negedge clk);
    filter_size = 5'(fs); ifmap_count = 8'(ic); go = 1'b1;
    if (wr_go) begin
      ld_wen = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = wdata; fmem[0] = wdata;
    end
    @(negedge clk);
    go = 1'b0; ld_wen = 1'b0;
    nf = 0; ni = 0; done_k = -1; fhold = 0; ihold = 0; fprev = '0; iprev = '0;
    for (int k = 1; k < 400; k++) begin
      filter_ready = (mode == 1) ? rpat[(k - 1) % 4] : 1'b1;
      ifmap_ready  = (mode == 1) ? rpat[(k + 1) % 4] : 1'b1;
      if (mode == 2) begin
        go = start | done;
        ld_wen = filter_wen; ld_sel = 1'b0; ld_addr = '0; ld_data = 16'hDEAD;
      end
      if (k == 1) begin
        chk({tag, " busy_after_go"}, int'(busy), 1);
        chk({tag, " filter_done_after_go"}, int'(filter_done), (exp_nf == 0) ? 1 : 0);
      end
      if (fhold) begin
        chk({tag, " filter_wen_held"}, int'(filter_wen), 1);
        chk({tag, " filter_din_held"}, int'(filter_din), int'(fprev));
      end
      if (ihold) begin
        chk({tag, " ifmap_wen_held"}, int'(ifmap_wen), 1);
        chk({tag, " ifmap_din_held"}, int'(ifmap_din), int'(iprev));
      end
      chk({tag, " start_eq_ifmap_wen"}, int'(start), int'(ifmap_wen));
      fhold = 0; ihold = 0;
      if (filter_wen) begin
        chk({tag, " filter_word"}, int'(filter_din), (nf < FD) ? int'(fmem[nf]) : -1);
        if (filter_ready) nf++;
        else begin fhold = 1; fprev = filter_din; end
      end
      if (ifmap_wen) begin
        chk({tag, " ifmap_word"}, int'(ifmap_din), (ni < ID) ? int'(imem[ni]) : -1);
        if (abort_at >= 0 && ni == abort_at) begin
          rst = 1'b1;
          #1;
          chk({tag, " outputs_zero_in_reset"}, any_out(), 0);
          @(negedge clk);
          rst = 1'b0; go = 1'b0; ld_wen = 1'b0; filter_ready = 1'b1; ifmap_ready = 1'b1;
          return;
        end
        if (ifmap_ready) ni++;
        else begin ihold = 1; iprev = ifmap_din; end
      end
      if (done) begin done_k = k; break; end
      @(negedge clk);
    end
    go = 1'b0; ld_wen = 1'b0; filter_ready = 1'b1; ifmap_ready = 1'b1;
    chk({tag, " done_seen"}, int'(done_k > 0), 1);
    chk({tag, " filter_words"}, nf, exp_nf);
    chk({tag, " ifmap_words"}, ni, exp_ni);
    if (exp_cyc >= 0) chk({tag, " go_to_done_cycles"}, done_k, exp_cyc);
    chk({tag, " busy_in_fin"}, int'(busy), 0);
    chk({tag, " start_in_fin"}, int'(start), 0);
    chk({tag, " filter_done_in_fin"}, int'(filter_done), 1);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, int'(done), 0);
    chk({tag, " idle_not_busy"}, int'(busy), 0);
    chk({tag, " filter_done_sticky"}, int'(filter_done), 1);
  endtask

  initial begin
    rst = 1'b1; ld_wen = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    filter_size = '0; ifmap_count = '0; go = 1'b0; filter_ready = 1'b1; ifmap_ready = 1'b1;

    vecs[0] = '{fs: 4,  ic: 24,  mode: 0, exp_nf: 4, exp_ni: 24, exp_cyc: 31};
    vecs[1] = '{fs: 0,  ic: 3,   mode: 0, exp_nf: 0, exp_ni: 3,  exp_cyc: 6};
    vecs[2] = '{fs: 31, ic: 200, mode: 0, exp_nf: 8, exp_ni: 32, exp_cyc: 43};
    vecs[3] = '{fs: 3,  ic: 0,   mode: 0, exp_nf: 3, exp_ni: 0,  exp_cyc: 6};
    vecs[4] = '{fs: 0,  ic: 0,   mode: 0, exp_nf: 0, exp_ni: 0,  exp_cyc: 3};
    vecs[5] = '{fs: 1,  ic: 1,   mode: 0, exp_nf: 1, exp_ni: 1,  exp_cyc: 5};
    vecs[6] = '{fs: 4,  ic: 5,   mode: 1, exp_nf: 4, exp_ni: 5,  exp_cyc: -1};

    #2;
    chk("reset_outputs_zero", any_out(), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) load(1'b0, i, 16'(i + 1));
    for (int i = 4; i < FD; i++) load(1'b0, i, 16'(16'h50 + i));
    for (int i = 0; i < 24; i++) load(1'b1, i, 16'(i));
    for (int i = 24; i < ID; i++) load(1'b1, i, 16'(16'h100 + i));
    load(1'b0, 8, 16'h5555);  // out-of-range filter address must not alias entry 0

    for (int i = 0; i < 7; i++) begin
      run_xfer($sformatf("vec%0d", i), vecs[i].fs, vecs[i].ic, vecs[i].mode,
               vecs[i].exp_nf, vecs[i].exp_ni, vecs[i].exp_cyc, -1, 1'b0, '0);
    end

    run_xfer("disturb", 4, 6, 2, 4, 6, 13, -1, 1'b0, '0);
    run_xfer("after_disturb", 4, 24, 0, 4, 24, 31, -1, 1'b0, '0);

    run_xfer("abort", 4, 24, 0, 4, 24, 31, 10, 1'b0, '0);
    chk("after_abort_idle", int'(busy), 0);
    run_xfer("after_abort", 4, 24, 0, 4, 24, 31, -1, 1'b0, '0);

    run_xfer("write_with_go", 2, 2, 0, 2, 2, 7, -1, 1'b1, 16'h0077);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
